// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use interlock: tracks in-flight register writes for DEPTH stages past decode.
// Latency: operand answers are combinational from the registered record array; the array updates one cycle after issue.
// Backpressure: stall holds decode and injects a bubble. Optional counters are built when FWD_STATS_EN is defined.
module fwd_scoreboard #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 3,
  parameter int LAT_W  = $clog2(DEPTH)
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          advance,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic                          issue_regwr,
  input  logic [REG_AW-1:0]             issue_rd,
  input  logic [LAT_W-1:0]              issue_lat,
  input  logic [DEPTH-1:0][DATA_W-1:0]  stage_data,
  input  logic [NSRC-1:0]               src_use,
  input  logic [NSRC-1:0][REG_AW-1:0]   src_reg,
  output logic [NSRC-1:0]               fwd_hit,
  output logic [NSRC-1:0][DATA_W-1:0]   fwd_data,
  output logic                          stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   fwd_count
`endif
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic [LAT_W-1:0]  cnt;
  } rec_t;

  rec_t [DEPTH-1:0] rec_q, rec_d;
  logic [NSRC-1:0]  matched;
  logic [LAT_W-1:0] lat_clip;

  // Youngest producer (lowest stage index) wins each query.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    stall    = 1'b0;
    matched  = '0;
    for (int q = 0; q < NSRC; q++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!matched[q] && src_use[q] && (src_reg[q] != '0) &&
            rec_q[k].vld && (rec_q[k].rd == src_reg[q])) begin
          matched[q] = 1'b1;
          if (rec_q[k].cnt == '0) begin
            fwd_hit[q]  = 1'b1;
            fwd_data[q] = stage_data[k];
          end else begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    lat_clip = (issue_lat > LAT_W'(DEPTH - 1)) ? LAT_W'(DEPTH - 1) : issue_lat;
    rec_d    = rec_q;
    if (advance) begin
      rec_d[0].vld = issue_valid & issue_regwr & (issue_rd != '0) & ~stall & ~flush;
      rec_d[0].rd  = issue_rd;
      rec_d[0].cnt = lat_clip;
      for (int k = 1; k < DEPTH; k++) begin
        rec_d[k].vld = rec_q[k-1].vld;
        rec_d[k].rd  = rec_q[k-1].rd;
        rec_d[k].cnt = (rec_q[k-1].cnt != '0) ? rec_q[k-1].cnt - LAT_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_count_q, fwd_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + ((stall && advance) ? 32'd1 : 32'd0);
    fwd_count_d    = fwd_count_q + ((advance && (|fwd_hit)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_count_q    <= fwd_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a table of sequential vectors plus hold and reset sequences.
module tb_fwd_scoreboard;

  localparam logic [31:0] SD0 = 32'h0000_1234;
  localparam logic [31:0] SD1 = 32'hAAAA_0001;
  localparam logic [31:0] SD2 = 32'hBBBB_0002;

  logic             CLK;
  logic             nRST;
  logic             advance, flush, issue_valid, issue_regwr;
  logic [4:0]       issue_rd;
  logic [1:0]       issue_lat;
  logic [2:0][31:0] stage_data;
  logic [2:0]       src_use;
  logic [2:0][4:0]  src_reg;
  logic [2:0]       fwd_hit;
  logic [2:0][31:0] fwd_data;
  logic             stall;
`ifdef FWD_STATS_EN
  logic [31:0]      stall_cycles, fwd_count;
`endif

  fwd_scoreboard dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .advance     (advance),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_regwr (issue_regwr),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .stage_data  (stage_data),
    .src_use     (src_use),
    .src_reg     (src_reg),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .stall       (stall)
`ifdef FWD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .fwd_count   (fwd_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // s0..s2 select the expected data per query: 0 = zero, 1..3 = stage_data[0..2].
  typedef struct {
    logic       adv, fl, iv, iw;
    logic [4:0] rd;
    logic [1:0] lat;
    logic [2:0] use_;
    logic [4:0] r0, r1, r2;
    logic [2:0] hit;
    logic [1:0] s0, s1, s2;
    logic       stl;
  } vec_t;

  vec_t tbl [17];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] sel_val(input logic [1:0] s);
    case (s)
      2'd1:    return SD0;
      2'd2:    return SD1;
      2'd3:    return SD2;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_stall"}, 128'(stall), 128'(1'b0));
    chk({nm, "_hit"}, 128'(fwd_hit), 128'(3'b000));
    chk({nm, "_data"}, 128'(fwd_data), 128'(0));
  endtask

  initial begin
    // adv fl iv iw rd lat use r0 r1 r2 hit s0 s1 s2 stall
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b1,5'd5, 2'd0,3'b000,5'd0, 5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b1,5'd8, 2'd1,3'b001,5'd5, 5'd0,5'd0,3'b001,2'd1,2'd0,2'd0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b1,5'd9, 2'd0,3'b011,5'd8, 5'd5,5'd0,3'b010,2'd0,2'd2,2'd0,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,5'd9, 2'd0,3'b111,5'd8, 5'd5,5'd9,3'b011,2'd2,2'd3,2'd0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,5'd10,2'd1,3'b111,5'd9, 5'd8,5'd0,3'b011,2'd1,2'd3,2'd0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b1,5'd6, 2'd0,3'b000,5'd0, 5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,5'd3, 2'd0,3'b111,5'd10,5'd9,5'd6,3'b111,2'd2,2'd3,2'd1,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b1,5'd7, 2'd0,3'b000,5'd0, 5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b1,1'b1,5'd3, 2'd0,3'b001,5'd3, 5'd0,5'd0,3'b001,2'd2,2'd0,2'd0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b1,5'd0, 2'd0,3'b011,5'd3, 5'd7,5'd0,3'b011,2'd1,2'd2,2'd0,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,5'd4, 2'd0,3'b111,5'd0, 5'd3,5'd7,3'b110,2'd0,2'd2,2'd3,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b0,5'd4, 2'd0,3'b111,5'd4, 5'd0,5'd3,3'b100,2'd0,2'd0,2'd3,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b1,1'b1,5'd12,2'd3,3'b001,5'd4, 5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,5'd0, 2'd0,3'b001,5'd12,5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b1};
    tbl[14] = '{1'b1,1'b0,1'b1,1'b1,5'd13,2'd0,3'b001,5'd12,5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b1};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,5'd0, 2'd0,3'b001,5'd12,5'd0,5'd0,3'b000,2'd0,2'd0,2'd0,1'b1};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,5'd0, 2'd0,3'b001,5'd12,5'd0,5'd0,3'b001,2'd3,2'd0,2'd0,1'b0};

    stage_data  = {SD2, SD1, SD0};
    nRST        = 1'b0;
    advance     = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_regwr = 1'b0;
    issue_rd    = 5'd0;
    issue_lat   = 2'd0;
    src_use     = 3'b111;
    src_reg     = {5'd5, 5'd5, 5'd5};

    #3;
    chk_idle("in_reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk_idle("post_reset");

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      advance     = tbl[i].adv;
      flush       = tbl[i].fl;
      issue_valid = tbl[i].iv;
      issue_regwr = tbl[i].iw;
      issue_rd    = tbl[i].rd;
      issue_lat   = tbl[i].lat;
      src_use     = tbl[i].use_;
      src_reg     = {tbl[i].r2, tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("row%0d_hit", i), 128'(fwd_hit), 128'(tbl[i].hit));
      chk($sformatf("row%0d_data", i), 128'(fwd_data),
          128'({sel_val(tbl[i].s2), sel_val(tbl[i].s1), sel_val(tbl[i].s0)}));
      chk($sformatf("row%0d_stall", i), 128'(stall), 128'(tbl[i].stl));
    end

    // Hold: a lat-1 record sits in stage 0 while advance is low.
    @(negedge CLK);
    advance = 1'b1; issue_valid = 1'b1; issue_regwr = 1'b1;
    issue_rd = 5'd20; issue_lat = 2'd1; src_use = 3'b000;
    @(negedge CLK);
    advance = 1'b0; issue_valid = 1'b0; issue_regwr = 1'b0;
    src_use = 3'b001; src_reg = {5'd0, 5'd0, 5'd20};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold%0d_stall", c), 128'(stall), 128'(1'b1));
      chk($sformatf("hold%0d_hit", c), 128'(fwd_hit), 128'(3'b000));
      @(negedge CLK);
    end
    advance = 1'b1;
    #1;
    chk("hold_adv_stall", 128'(stall), 128'(1'b1));
    @(negedge CLK);
    #1;
    chk("hold_release_stall", 128'(stall), 128'(1'b0));
    chk("hold_release_hit", 128'(fwd_hit), 128'(3'b001));
    chk("hold_release_data", 128'(fwd_data), 128'({32'h0, 32'h0, SD1}));

    // Reset asserted while a load-use stall is pending.
    @(negedge CLK);
    issue_valid = 1'b1; issue_regwr = 1'b1; issue_rd = 5'd21; issue_lat = 2'd1;
    src_use = 3'b000;
    @(negedge CLK);
    issue_valid = 1'b0; issue_regwr = 1'b0;
    src_use = 3'b001; src_reg = {5'd0, 5'd0, 5'd21};
    #1;
    chk("rst_pre_stall", 128'(stall), 128'(1'b1));
    #1;
    nRST = 1'b0;
    #1;
    chk_idle("rst_async");
`ifdef FWD_STATS_EN
    chk("rst_stall_cycles", 128'(stall_cycles), 128'(0));
    chk("rst_fwd_count", 128'(fwd_count), 128'(0));
`endif
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk_idle("rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
